// File: rtl/serial_byte_loader.sv
// serial_byte_loader: assembles a framed serial bit stream into a word,
// optionally checks even parity, and pulses load for the downstream register.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             perr_q, perr_d;

  logic [WIDTH-1:0] sr_next;
  logic             last_bit;
  logic             par_ok;

  always_comb begin
    if (MSB_FIRST) sr_next = {sr_q[WIDTH-2:0], serial_in};
    else           sr_next = {serial_in, sr_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
    par_ok   = ~(^sr_q ^ serial_in);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          if (PARITY_EN) state_d = PARITY;
          else           state_d = LOAD;
        end
      end
      PARITY: begin
        if (par_ok) state_d = LOAD;
        else        state_d = IDLE;
      end
      LOAD: begin
        if (start) state_d = SHIFT;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath and registered outputs follow the current state
  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    dout_d = dout_q;
    load_d = 1'b0;
    perr_d = perr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          perr_d = 1'b0;
        end
      end
      SHIFT: begin
        sr_d  = sr_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit && !PARITY_EN) begin
          dout_d = sr_next;
          load_d = 1'b1;
        end
      end
      PARITY: begin
        if (par_ok) begin
          dout_d = sr_q;
          load_d = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d  = '0;
          perr_d = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == SHIFT) || (state_d == PARITY);
  end

  assign data_out   = dout_q;
  assign load       = load_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Upstream feeder for the 8-bit parallel-load register. It assembles a framed serial bit stream into a WIDTH-bit word and optionally checks even parity. On each good frame it presents the word on data_out with a one-cycle load pulse. data_out and load connect directly to the register's data_in and load inputs, on the same Clk.

Parameters:
WIDTH, 8, number of data bits per frame; also the data_out width.
MSB_FIRST, 1, 1 = first received data bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit and no check.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  frame-start strobe; sampled on Clk.
serial_in  input  1  serial data bit; sampled on Clk.
data_out  output  WIDTH  last good word; drives the register's data_in.
load  output  1  one-cycle pulse marking data_out as new; drives the register's load.
busy  output  1  high while a frame is in progress (SHIFT or PARITY state).
parity_err  output  1  sticky flag for the last frame's parity failure.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bit counter=0, shift register=0, data_out=0, load=0, busy=0, parity_err=0. Reset takes effect immediately, including mid-frame; the partial frame is discarded.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, SHIFT, PARITY, LOAD.
- IDLE: on an edge with start=1 -> SHIFT, counter=0, parity_err cleared. serial_in is not sampled on this edge.
- SHIFT: samples serial_in on each edge into the shift register, MSB_FIRST ordering. After WIDTH samples -> PARITY if PARITY_EN=1, otherwise directly to the good-frame path.
- PARITY: samples the parity bit on one edge. If XOR of the data bits and the parity bit is 0, the frame is good; otherwise it is bad.
- Good frame: on the same edge, data_out <= assembled word, load <= 1, state -> LOAD.
- Bad frame: parity_err <= 1, load stays 0, data_out unchanged, state -> IDLE.
- LOAD: lasts exactly one cycle; load=1 during it. Next edge: load <= 0 and state -> IDLE; if start=1 on that edge, state -> SHIFT instead (back-to-back frames).
- start is ignored in SHIFT and PARITY (busy=1).
- Latency with start sampled at edge 0 and PARITY_EN=1:
  - data bits sampled at edges 1..WIDTH;
  - parity bit sampled at edge WIDTH+1;
  - load high between edges WIDTH+1 and WIDTH+2;
  - downstream register captures at edge WIDTH+2.
  With PARITY_EN=0, every edge after the data bits moves one earlier.
- Output stability: data_out changes only on the edge that raises load, and holds its value between frames. parity_err holds until the next accepted start or reset.
- Counter width is clog2(WIDTH+1). The counter does not wrap within a frame.

Test Plan:
1. Defaults, good frame: reset then release; start at edge 0; bits 1,0,1,0,0,1,0,1 (MSB first) at edges 1-8; parity 0 at edge 9 -> load=1 for exactly one cycle after edge 9, data_out=0xA5, parity_err=0, busy low after edge 9.
2. Parity error: after test 1, frame 0x3C with parity bit 1 -> parity_err=1, load never asserted, data_out stays 0xA5. Next good frame 0x0F with parity 0 -> parity_err cleared at start, data_out=0x0F.
3. Reset mid-frame: reset=0 after 4 bits of 0xFF -> data_out=0, busy=0, load=0 immediately. Release and send 0x81 with parity 0 -> data_out=0x81.
4. Back-to-back and ignored start: start asserted during the LOAD cycle of 0xA5 -> second frame 0xFF with parity 0 loads, load high after edge 19. A start pulse at edge 3 of a frame has no effect.
5. PARITY_EN=0, MSB_FIRST=0: bits 1,0,0,0,0,0,0,0 -> data_out=0x01, load high after edge 8.
6. Pair with the 8-bit register: after each good frame the register's stored value equals data_out one edge after load; after a bad frame stored is unchanged.
